// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and defaults for the instruction-fetch stage
//
// Purpose: FSM state enum, reset/NOP defaults and the IF/ID payload struct
// used by if_stage, if_id_reg and the fetch bus interface.
// Ports: none (package).
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.valid = 1'b0;
    b.pc    = 32'h0000_0000;
    b.instr = nop;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: control inputs, imem handshake, IF/ID outputs
//
// Purpose: groups the pipeline control, instruction-memory and decode-facing
// signals of the fetch stage.
// Modports:
//   master - the fetch stage (drives imem_req/imem_addr and if_*)
//   slave  - the environment (drives freeze/branch and the memory response)
interface if_stage_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load/hold/flush
//
// Purpose: holds the instruction handed to decode.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   flush_i   - load a bubble {0, 0, NOP}; wins over load_i
//   load_i    - load d_i; otherwise hold
//   d_i, q_o  - payload in / registered payload out
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INST_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush_i,
  input  logic  load_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_o <= ifid_bubble(NOP_WORD);
    end else if (flush_i) begin
      q_o <= ifid_bubble(NOP_WORD);
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, single-outstanding fetch, skid, IF/ID
//
// Purpose: owns the PC, issues one instruction-memory request at a time and
// loads the IF/ID register; honours decode freeze and execute branch redirect.
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous active-low reset
//   bus  - if_stage_if.master (freeze/branch in, imem handshake, IF/ID out)
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        ifid_load;
  logic        ifid_flush;
  ifid_t       ifid_d;
  ifid_t       ifid_q;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_plus4;
    ifid_d.instr = bus.imem_rdata;

    if (bus.branch_taken) begin
      // Redirect beats freeze. A request still in flight must be allowed
      // to complete (DRAIN) before the new target can be fetched.
      ifid_flush   = 1'b1;
      skid_pc_d    = 32'h0000_0000;
      skid_instr_d = NOP_INST;
      pc_d         = bus.branch_addr;
      if ((state_q == FETCH || state_q == DRAIN) && !bus.imem_rvalid) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (bus.imem_rvalid) begin
            pc_d = pc_plus4;
            if (bus.freeze) begin
              skid_pc_d    = pc_plus4;
              skid_instr_d = bus.imem_rdata;
              state_d      = HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!bus.freeze) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!bus.freeze) begin
            ifid_load    = 1'b1;
            ifid_d.pc    = skid_pc_q;
            ifid_d.instr = skid_instr_q;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (bus.imem_rvalid) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_d  = (state_d == FETCH) || (state_d == DRAIN);
    // DRAIN keeps presenting the pre-branch address until its data returns.
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      skid_pc_q    <= 32'h0000_0000;
      skid_instr_q <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = ifid_q.valid;
  assign bus.if_pc     = ifid_q.pc;
  assign bus.if_instr  = ifid_q.instr;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with a behavioural fetch model
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Memory: one response per request after mem_lat cycles; data = addr ^ A5A5_0000.
  int unsigned lat_min = 0;
  int unsigned lat_max = 0;
  int unsigned mem_cnt;
  int unsigned mem_lat;

  assign bus.imem_rvalid = bus.imem_req && (mem_cnt == mem_lat);
  assign bus.imem_rdata  = bus.imem_addr ^ 32'hA5A5_0000;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cnt <= 0;
      mem_lat <= lat_min;
    end else if (bus.imem_req) begin
      if (bus.imem_rvalid) begin
        mem_cnt <= 0;
        mem_lat <= $urandom_range(lat_max, lat_min);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // Stimulus applied for the current cycle.
  logic        fz;
  logic        br;
  logic [31:0] ba;

  // Behavioural model: what the stage must present, derived from the fetch rules.
  logic        m_started, m_req, m_drain, m_skv;
  logic [31:0] m_pc, m_addr, m_skpc, m_ski;
  logic        m_ifv;
  logic [31:0] m_ifpc, m_ifi;

  task automatic model_reset();
    m_started = 1'b0; m_req = 1'b0; m_drain = 1'b0; m_skv = 1'b0;
    m_pc = 32'h0; m_addr = 32'h0; m_skpc = 32'h0; m_ski = 32'h0;
    m_ifv = 1'b0; m_ifpc = 32'h0; m_ifi = 32'h0;
  endtask

  task automatic model_step(input logic rv);
    logic [31:0] word;
    logic        pending;
    word    = m_addr ^ 32'hA5A5_0000;
    pending = m_req && !rv;
    if (br) begin
      m_ifv = 1'b0; m_ifi = 32'h0; m_ifpc = 32'h0; m_skv = 1'b0;
      if (!pending) m_addr = ba;
      m_drain   = pending;
      m_req     = 1'b1;
      m_pc      = ba;
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1; m_req = 1'b1; m_addr = m_pc;
    end else if (m_skv) begin
      if (!fz) begin
        m_ifv = 1'b1; m_ifpc = m_skpc; m_ifi = m_ski;
        m_skv = 1'b0; m_req = 1'b1; m_addr = m_pc;
      end
    end else if (m_drain) begin
      if (rv) begin
        m_drain = 1'b0; m_addr = m_pc;
      end
    end else if (rv) begin
      m_pc = m_addr + 32'd4;
      if (fz) begin
        m_skv = 1'b1; m_skpc = m_pc; m_ski = word; m_req = 1'b0;
      end else begin
        m_ifv = 1'b1; m_ifpc = m_pc; m_ifi = word; m_addr = m_pc;
      end
    end else if (!fz) begin
      m_ifv = 1'b0; m_ifi = 32'h0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, compare against the model, step the model.
  task automatic cycle();
    logic rv;
    bus.freeze       = fz;
    bus.branch_taken = br;
    bus.branch_addr  = ba;
    #1;
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, m_req});
    if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
    chk("if_valid", {31'h0, bus.if_valid}, {31'h0, m_ifv});
    chk("if_instr", bus.if_instr, m_ifi);
    if (m_ifv) chk("if_pc", bus.if_pc, m_ifpc);
    rv = bus.imem_rvalid;
    @(posedge clk);
    model_step(rv);
    @(negedge clk);
  endtask

  task automatic set_in(input logic f, input logic b, input logic [31:0] a);
    fz = f; br = b; ba = a;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'h0, bus.imem_req}, 32'h0);
    chk({tag, "_valid"}, {31'h0, bus.if_valid}, 32'h0);
    chk({tag, "_pc"},    bus.if_pc, 32'h0);
    chk({tag, "_instr"}, bus.if_instr, 32'h0);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 32'h0);
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
    model_reset();
    #3 rst = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Zero-latency streaming.
    cycle();
    chk("c2_req", {31'h0, bus.imem_req}, 32'h1);
    chk("c2_addr", bus.imem_addr, 32'h0);
    cycle();
    chk("c3_addr", bus.imem_addr, 32'h4);
    chk("c3_valid", {31'h0, bus.if_valid}, 32'h1);
    chk("c3_pc", bus.if_pc, 32'h4);
    cycle();
    chk("c4_addr", bus.imem_addr, 32'h8);
    chk("c4_pc", bus.if_pc, 32'h8);
    chk("c4_instr", bus.if_instr, 32'hA5A5_0004);
    cycle();
    chk("c5_pc", bus.if_pc, 32'hC);

    // Freeze for 3 cycles, fetch of 0xC returns in the first frozen cycle.
    set_in(1'b1, 1'b0, 32'h0);
    cycle();
    chk("hold_req", {31'h0, bus.imem_req}, 32'h0);
    chk("hold_pc1", bus.if_pc, 32'hC);
    cycle();
    chk("hold_pc2", bus.if_pc, 32'hC);
    cycle();
    chk("hold_pc3", bus.if_pc, 32'hC);
    set_in(1'b0, 1'b0, 32'h0);
    cycle();
    chk("skid_instr", bus.if_instr, 32'hA5A5_000C);
    chk("skid_pc", bus.if_pc, 32'h10);
    chk("skid_next_addr", bus.imem_addr, 32'h10);

    // Branch to the top of the address space: PC wraps to 0.
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle();
    chk("br_flush", {31'h0, bus.if_valid}, 32'h0);
    chk("br_addr", bus.imem_addr, 32'hFFFF_FFFC);
    lat_min = 3; lat_max = 3;
    set_in(1'b0, 1'b0, 32'h0);
    cycle();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_pc", bus.if_pc, 32'h0);
    chk("wrap_instr", bus.if_instr, 32'h5A5A_FFFC);

    // Latency-3 drains: branch to 0x20, then to 0x100 while 0x20 is pending.
    set_in(1'b0, 1'b1, 32'h20);
    cycle();
    chk("drain_keep_addr", bus.imem_addr, 32'h0);
    set_in(1'b0, 1'b0, 32'h0);
    repeat (3) cycle();
    chk("addr_20", bus.imem_addr, 32'h20);
    cycle();
    set_in(1'b0, 1'b1, 32'h100);
    cycle();
    chk("drain20_addr", bus.imem_addr, 32'h20);
    chk("drain20_flush", {31'h0, bus.if_valid}, 32'h0);
    lat_min = 0; lat_max = 0;
    set_in(1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    chk("redirect_addr", bus.imem_addr, 32'h100);
    chk("redirect_discard", {31'h0, bus.if_valid}, 32'h0);
    cycle();
    chk("redirect_pc", bus.if_pc, 32'h104);
    chk("redirect_instr", bus.if_instr, 32'hA5A5_0100);

    // Branch and freeze together while in HOLD.
    set_in(1'b1, 1'b0, 32'h0);
    cycle();
    chk("hold2_req", {31'h0, bus.imem_req}, 32'h0);
    set_in(1'b1, 1'b1, 32'h200);
    cycle();
    chk("hb_flush", {31'h0, bus.if_valid}, 32'h0);
    chk("hb_addr", bus.imem_addr, 32'h200);
    set_in(1'b0, 1'b0, 32'h0);
    cycle();
    chk("hb_pc", bus.if_pc, 32'h204);

    // Latency-2 stretch.
    lat_min = 2; lat_max = 2;
    repeat (14) cycle();

    // Asynchronous reset between edges.
    lat_min = 0; lat_max = 0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("refetch_addr", bus.imem_addr, 32'h0);
    chk("refetch_req", {31'h0, bus.imem_req}, 32'h1);

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      fz = ($urandom_range(3, 0) == 0);
      br = ($urandom_range(11, 0) == 0);
      if ($urandom_range(3, 0) == 0) ba = 32'hFFFF_FFF4 + 32'($urandom_range(2, 0)) * 32'd4;
      else ba = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
